// File: rtl/prince_cms_pkg.sv
// Shared types and constants for the CMS-masked PRINCE inverse S-box.
// Optional self-check is enabled with PRINCE_INV_SBOX_SELFCHECK_EN.
package prince_cms_pkg;

    localparam int RAND_W = 32;

    typedef logic [3:0] nibble_t;
    typedef logic [3:0][7:0] exp_shares_t;

    localparam nibble_t PRINCE_INV_SBOX [16] = '{
        4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
    };

    // Algebraic normal form of one output bit (Moebius transform of the LUT)
    function automatic logic [15:0] inv_sbox_anf(input int b);
        logic [15:0] v;
        for (int m = 0; m < 16; m++) begin
            v[4'(m)] = PRINCE_INV_SBOX[4'(m)][2'(b)];
        end
        for (int i = 0; i < 4; i++) begin
            for (int m = 0; m < 16; m++) begin
                if (((m >> i) & 1) != 0) begin
                    v[4'(m)] = v[4'(m)] ^ v[4'(m ^ (1 << i))];
                end
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/prince_inv_sbox_cms_expand.sv
// Non-complete cubic expansion of a 2-share nibble into 8 shares per bit,
// followed by a ring refresh. Purely combinational.
module prince_inv_sbox_cms_expand
    import prince_cms_pkg::*;
(
    input  nibble_t             sh0_i,
    input  nibble_t             sh1_i,
    input  logic [RAND_W-1:0]   rand_i,
    output exp_shares_t         q_o
);

    exp_shares_t e;

    // Share index used for input bit i in component j; any three of these
    // selectors are linearly independent, so every cubic cross term appears.
    function automatic logic sel(input int i, input int j);
        logic [2:0] jj;
        jj = 3'(j);
        if (i == 3) return ^jj;
        return jj[2'(i)];
    endfunction

    function automatic logic comp(input int b, input int j,
                                  input nibble_t a0, input nibble_t a1);
        logic [15:0] anf;
        logic        r;
        logic        canon;
        logic        same;
        logic        prod;
        anf = inv_sbox_anf(b);
        r = 1'b0;
        for (int m = 0; m < 16; m++) begin
            if (anf[4'(m)]) begin
                canon = 1'b1;
                for (int jp = 0; jp < j; jp++) begin
                    same = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (((m >> i) & 1) != 0 && sel(i, jp) != sel(i, j))
                            same = 1'b0;
                    end
                    if (same) canon = 1'b0;
                end
                if (canon) begin
                    prod = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (((m >> i) & 1) != 0)
                            prod = prod & (sel(i, j) ? a1[2'(i)] : a0[2'(i)]);
                    end
                    r = r ^ prod;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        e   = '0;
        q_o = '0;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) begin
                e[2'(b)][3'(j)] = comp(b, j, sh0_i, sh1_i);
                q_o[2'(b)][3'(j)] = e[2'(b)][3'(j)]
                                  ^ rand_i[5'(8 * b + j)]
                                  ^ rand_i[5'(8 * b + (j + 1) % 8)];
            end
        end
    end

endmodule

// File: rtl/prince_inv_sbox_cms.sv
// Two-stage elastic CMS-masked PRINCE inverse S-box (expand+refresh, compress).
// Define PRINCE_INV_SBOX_SELFCHECK_EN (simulation only) to add err_o.
module prince_inv_sbox_cms
    import prince_cms_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_sh0,
    input  logic [3:0]        in_sh1,
    input  logic [RAND_W-1:0] rand_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_sh0,
`ifdef PRINCE_INV_SBOX_SELFCHECK_EN
    output logic [3:0]        out_sh1,
    output logic              err_o
`else
    output logic [3:0]        out_sh1
`endif
);

    exp_shares_t exp_d;
    (* keep = "true" *) exp_shares_t s1_q;
    logic        v1_q;
    logic        v2_q;
    nibble_t     sh0_q, sh0_d;
    nibble_t     sh1_q, sh1_d;
    logic        adv1;
    logic        adv2;

    prince_inv_sbox_cms_expand u_expand (
        .sh0_i  (in_sh0),
        .sh1_i  (in_sh1),
        .rand_i (rand_i),
        .q_o    (exp_d)
    );

    assign adv2      = !v2_q || out_ready;
    assign adv1      = !v1_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign out_sh0   = sh0_q;
    assign out_sh1   = sh1_q;

    always_comb begin
        sh0_d = '0;
        sh1_d = '0;
        for (int b = 0; b < 4; b++) begin
            sh0_d[2'(b)] = ^s1_q[2'(b)][3:0];
            sh1_d[2'(b)] = ^s1_q[2'(b)][7:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            s1_q  <= '0;
            sh0_q <= '0;
            sh1_q <= '0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv1 && in_valid) s1_q <= exp_d;
            if (adv2) v2_q <= v1_q;
            if (adv2 && v1_q) begin
                sh0_q <= sh0_d;
                sh1_q <= sh1_d;
            end
        end
    end

`ifdef PRINCE_INV_SBOX_SELFCHECK_EN
    nibble_t raw1_q;
    nibble_t raw2_q;
    logic    err_q;
    logic    mism;

    assign mism  = v2_q && ((sh0_q ^ sh1_q) != PRINCE_INV_SBOX[raw2_q]);
    assign err_o = err_q || mism;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw1_q <= '0;
            raw2_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (adv1 && in_valid) raw1_q <= in_sh0 ^ in_sh1;
            if (adv2 && v1_q) raw2_q <= raw1_q;
            err_q <= err_q || mism;
        end
    end
`endif

endmodule

// File: tb/tb_prince_inv_sbox_cms.sv
// Self-checking bench for prince_inv_sbox_cms: randomized traffic against
// an in-order transaction model plus directed corner cases.
module tb_prince_inv_sbox_cms;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_sh0 = '0;
    logic [3:0]  in_sh1 = '0;
    logic [31:0] rand_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_sh0;
    logic [3:0]  out_sh1;
`ifdef PRINCE_INV_SBOX_SELFCHECK_EN
    logic        err_o;
`endif

    always #5 clk = ~clk;

    prince_inv_sbox_cms dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh0    (in_sh0),
        .in_sh1    (in_sh1),
        .rand_i    (rand_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh0   (out_sh0),
`ifdef PRINCE_INV_SBOX_SELFCHECK_EN
        .out_sh1   (out_sh1),
        .err_o     (err_o)
`else
        .out_sh1   (out_sh1)
`endif
    );

    logic [3:0] ref_tab [16] = '{
        4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
    };

    typedef struct {
        logic [3:0] val;
        int         avail;
    } item_t;

    item_t      pipe_q[$];
    logic [3:0] outs[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         accepts = 0;
    logic       stall_prev = 1'b0;
    logic [3:0] p0, p1;
    logic       last_ov;
    logic       track = 1'b0;
    logic [15:0] seen0 = '0;
    logic [3:0] bpv [3] = '{4'h1, 4'h2, 4'h3};

    function automatic logic [3:0] sinv(input logic [3:0] x);
        return ref_tab[x];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic put(input logic v, input logic [3:0] x, input logic ordy);
        logic [3:0] m;
        m = 4'($urandom);
        in_valid  = v;
        in_sh0    = x ^ m;
        in_sh1    = m;
        rand_i    = $urandom;
        out_ready = ordy;
    endtask

    // Called at a falling edge with inputs driven; checks and books the cycle.
    task automatic tick();
        logic exp_ov;
        #1;
        exp_ov = pipe_q.size() > 0 && pipe_q[0].avail <= cyc;
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(pipe_q.size() < 2 || out_ready));
        if (exp_ov && out_valid)
            chk("unmasked_out", 32'(out_sh0 ^ out_sh1), 32'(pipe_q[0].val));
        if (stall_prev) begin
            chk("hold_sh0", 32'(out_sh0), 32'(p0));
            chk("hold_sh1", 32'(out_sh1), 32'(p1));
        end
        stall_prev = out_valid && !out_ready;
        p0 = out_sh0;
        p1 = out_sh1;
        last_ov = out_valid;
        if (track && out_valid) seen0[out_sh0] = 1'b1;
        if (out_valid && out_ready) begin
            outs.push_back(out_sh0 ^ out_sh1);
            if (pipe_q.size() > 0) void'(pipe_q.pop_front());
        end
        if (in_valid && in_ready) begin
            pipe_q.push_back(item_t'{val: sinv(in_sh0 ^ in_sh1), avail: cyc + 2});
            accepts++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        pipe_q.delete();
        stall_prev = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sh0", 32'(out_sh0), 32'd0);
        chk("rst_sh1", 32'(out_sh1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic single(input string name, input logic [3:0] s0,
                          input logic [3:0] s1, input logic [31:0] r,
                          input logic [3:0] exp);
        in_valid = 1'b1;
        in_sh0 = s0;
        in_sh1 = s1;
        rand_i = r;
        out_ready = 1'b1;
        outs.delete();
        tick();
        put(1'b0, 4'h0, 1'b1);
        for (int t = 0; t < 8 && outs.size() == 0; t++) tick();
        if (outs.size() == 0)
            chk({name, "_timeout"}, 32'd0, 32'd1);
        else
            chk(name, 32'(outs[0]), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bubbles;
        @(negedge clk);
        do_reset();

        single("lit_0", 4'h5, 4'h5, $urandom, 4'hB);
        single("lit_4", 4'h7, 4'h3, $urandom, 4'hF);
        single("lit_F", 4'hA, 4'h5, $urandom, 4'h1);
        single("lit_9", 4'h9, 4'h0, $urandom, 4'h6);

        for (int x = 0; x < 16; x++)
            for (int k = 0; k < 4; k++) begin
                put(1'b1, 4'(x), 1'b1);
                tick();
            end
        put(1'b0, 4'h0, 1'b1);
        repeat (4) tick();

        outs.delete();
        accepts = 0;
        for (int t = 0; t < 5; t++) begin
            put(accepts < 3, bpv[accepts < 3 ? accepts : 0], 1'b0);
            tick();
        end
        chk("bp_accepts", 32'(accepts), 32'd2);
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_hold_val", 32'(out_sh0 ^ out_sh1), 32'h7);
        for (int t = 0; t < 10; t++) begin
            put(accepts < 3, bpv[accepts < 3 ? accepts : 0], 1'b1);
            tick();
        end
        chk("bp_count", 32'(outs.size()), 32'd3);
        if (outs.size() == 3) begin
            chk("bp_order0", 32'(outs[0]), 32'h7);
            chk("bp_order1", 32'(outs[1]), 32'h3);
            chk("bp_order2", 32'(outs[2]), 32'h2);
        end

        seen0 = '0;
        track = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            put(1'b1, 4'h9, 1'b1);
            tick();
        end
        put(1'b0, 4'h0, 1'b1);
        repeat (3) tick();
        track = 1'b0;
        chk("rand_sh0_cover", 32'(seen0), 32'hFFFF);
        single("zero_rand_9", 4'h9, 4'h0, 32'h0, 4'h6);

        put(1'b1, 4'hC, 1'b1);
        tick();
        put(1'b0, 4'h0, 1'b1);
        rst_n = 1'b0;
        pipe_q.delete();
        stall_prev = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sh0", 32'(out_sh0), 32'd0);
        chk("midrst_sh1", 32'(out_sh1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        outs.delete();
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);
        repeat (5) tick();
        chk("no_stale", 32'(outs.size()), 32'd0);

        bubbles = 0;
        for (int k = 0; k < 66; k++) begin
            put(k < 64, 4'($urandom), 1'b1);
            tick();
            if (k >= 2 && !last_ov) bubbles++;
        end
        chk("fullrate_bubbles", 32'(bubbles), 32'd0);

        for (int t = 0; t < 2000; t++) begin
            put($urandom_range(3, 0) != 0, 4'($urandom),
                $urandom_range(2, 0) != 0);
            tick();
        end
        put(1'b0, 4'h0, 1'b1);
        repeat (8) tick();
        chk("drained", 32'(pipe_q.size()), 32'd0);

`ifdef PRINCE_INV_SBOX_SELFCHECK_EN
        chk("err_clean", 32'(err_o), 32'd0);
        put(1'b1, 4'h0, 1'b1);
        tick();
        put(1'b0, 4'h0, 1'b1);
        force dut.s1_q = '0;
        @(negedge clk);
        #1;
        chk("err_set", 32'(err_o), 32'd1);
        release dut.s1_q;
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(err_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("err_reset", 32'(err_o), 32'd0);
        pipe_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
